// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared opcodes, state/class encodings and IR fields for instr_sequencer
package instr_sequencer_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_AR_LO = 4'h1;
    localparam logic [3:0] OP_AR_HI = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_MOVI  = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic SEL_AR = 1'b0;
    localparam logic SEL_T  = 1'b1;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEMACC,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_AR,
        CLS_LOAD,
        CLS_STORE,
        CLS_MOVI,
        CLS_HALT,
        CLS_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational opcode classifier and IR-to-regbank mux selects
module instr_decode
    import instr_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output iclass_t    iclass,
    output logic       dest_sel,
    output logic       const_sel
);

    always_comb begin
        iclass = CLS_ILLEGAL;
        case (opcode)
            OP_NOP:   iclass = CLS_NOP;
            OP_LOAD:  iclass = CLS_LOAD;
            OP_STORE: iclass = CLS_STORE;
            OP_MOVI:  iclass = CLS_MOVI;
            OP_HALT:  iclass = CLS_HALT;
            default: begin
                if (opcode >= OP_AR_LO && opcode <= OP_AR_HI) begin
                    iclass = CLS_AR;
                end
            end
        endcase
    end

    // Only the T-type classes route the T fields; everything else keeps the AR path.
    always_comb begin
        dest_sel  = SEL_AR;
        const_sel = SEL_AR;
        if (iclass == CLS_LOAD || iclass == CLS_STORE || iclass == CLS_MOVI) begin
            dest_sel  = SEL_T;
            const_sel = SEL_T;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/exec FSM owning PC and IR; INSTR_SEQ_TIMEOUT_EN adds mem_ack timeout and bus_err
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W        = 32,
`ifdef INSTR_SEQ_TIMEOUT_EN
    parameter int unsigned     TIMEOUT_CYC = 15,
`endif
    parameter logic [PC_W-1:0] PC_RESET    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_is_data,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     ir,
    output logic            alu_start,
    input  logic            alu_done,
    output logic            dest_sel,
    output logic            const_sel,
    output logic            rb_we,
    output logic            halted,
`ifdef INSTR_SEQ_TIMEOUT_EN
    output logic            bus_err,
`endif
    output logic            illegal
);

    state_t  state;
    state_t  state_nx;
    iclass_t iclass;
    logic    dec_dest_sel;
    logic    dec_const_sel;
    logic    timeout;

    instr_decode u_decode (
        .opcode    (ir[OPC_MSB:OPC_LSB]),
        .iclass    (iclass),
        .dest_sel  (dec_dest_sel),
        .const_sel (dec_const_sel)
    );

`ifdef INSTR_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;

    assign waiting = mem_req && !mem_ack;
    // Fires on the TIMEOUT_CYC-th consecutive unacknowledged request cycle.
    assign timeout = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (state_nx != state || !waiting) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH: begin
                if (mem_ack) begin
                    state_nx = ST_DECODE;
                end else if (timeout) begin
                    state_nx = ST_HALT;
                end
            end
            ST_DECODE: begin
                case (iclass)
                    CLS_HALT:            state_nx = ST_HALT;
                    CLS_AR:              state_nx = ST_EXEC;
                    CLS_LOAD, CLS_STORE: state_nx = ST_MEMACC;
                    CLS_MOVI:            state_nx = ST_WB;
                    default:             state_nx = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                if (alu_done) begin
                    state_nx = ST_WB;
                end
            end
            ST_MEMACC: begin
                if (mem_ack) begin
                    state_nx = (iclass == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (timeout) begin
                    state_nx = ST_HALT;
                end
            end
            ST_WB:   state_nx = ST_FETCH;
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_FETCH;
        endcase
    end

    // Requests are gated by reset so an in-flight handshake drops without waiting for a clock.
    always_comb begin
        mem_req     = 1'b0;
        mem_is_data = 1'b0;
        mem_we      = 1'b0;
        rb_we       = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_FETCH:  mem_req = !reset;
            ST_MEMACC: begin
                mem_req     = !reset;
                mem_is_data = 1'b1;
                mem_we      = (iclass == CLS_STORE) && !reset;
            end
            ST_DECODE: illegal = (iclass == CLS_ILLEGAL);
            ST_WB:     rb_we   = 1'b1;
            ST_HALT:   halted  = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= PC_RESET;
            ir        <= '0;
            dest_sel  <= SEL_AR;
            const_sel <= SEL_AR;
            alu_start <= 1'b0;
        end else begin
            alu_start <= (state == ST_DECODE) && (iclass == CLS_AR);
            if (state == ST_FETCH && mem_ack) begin
                ir <= mem_rdata;
                pc <= pc + PC_W'(4);
            end
            if (state == ST_DECODE) begin
                dest_sel  <= dec_dest_sel;
                const_sel <= dec_const_sel;
            end
        end
    end

endmodule
